// File: rtl/gate_sweep_checker.sv
// Sweeps every input vector onto a combinational gate, samples its output after a
// settle time, and compares against EXPECTED. Optional SWEEP_EARLY_ABORT_EN stops at first miss.
module gate_sweep_checker #(
  parameter int N_INPUTS = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter logic [2**N_INPUTS-1:0] EXPECTED = 4'b1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [N_INPUTS-1:0]     vec,
  input  logic                    y_in,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [2**N_INPUTS-1:0]  truth_table,
  output logic [N_INPUTS:0]       mismatch_count
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] VEC_LAST = '1;

`ifdef SWEEP_EARLY_ABORT_EN
  localparam bit EARLY_ABORT = 1'b1;
`else
  localparam bit EARLY_ABORT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     settle_cnt;
  logic                 miss;
  logic [N_INPUTS:0]    mismatch_next;

  assign miss          = (y_in != EXPECTED[vec]);
  assign mismatch_next = mismatch_count + (N_INPUTS+1)'(miss);

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = SETTLE;
      end
      SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == SETTLE_LAST) state_next = SAMPLE;
      end
      SAMPLE: begin
        busy = 1'b1;
        if ((vec == VEC_LAST) || (EARLY_ABORT && miss)) state_next = DONE;
        else state_next = SETTLE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      settle_cnt     <= '0;
      vec            <= '0;
      truth_table    <= '0;
      mismatch_count <= '0;
      pass           <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            vec            <= '0;
            settle_cnt     <= '0;
            truth_table    <= '0;
            mismatch_count <= '0;
            pass           <= 1'b0;
          end
        end
        SETTLE: begin
          settle_cnt <= (settle_cnt == SETTLE_LAST) ? '0 : settle_cnt + 1'b1;
        end
        SAMPLE: begin
          truth_table[vec] <= y_in;
          mismatch_count   <= mismatch_next;
          // pass is resolved here so it is already valid during the done cycle
          if (state_next == DONE) pass <= (mismatch_next == '0);
          else vec <= vec + 1'b1;
        end
        DONE: begin
          vec <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Sequential stimulus and response checker for the basic combinational gates in this codebase, e.g. `and_gate` with inputs `a`, `b` and output `y`.
- On `start` it drives every input combination onto the gate under test in turn and samples the gate's `y` after a programmable settle time.
- It assembles the observed truth table, compares each sample against an expected table, and reports pass/fail with a one-cycle `done` pulse.
- It sits directly around the gate: it feeds the gate's inputs and consumes its output, replacing hand-written per-gate stimulus blocks with one synthesizable checker.

## Interface
- `N_INPUTS`, default 2: number of gate inputs; range 1–4.
- `SETTLE_CYCLES`, default 2: cycles each vector is held before its sample cycle; minimum 1.
- `EXPECTED`, default `4'b1000` (AND): expected truth table, width 2**N_INPUTS; bit i is the expected `y` for vector i.
- `clk`  in  1  the only clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  sweep request; sampled only in IDLE.
- `vec`  out  N_INPUTS  drives the gate inputs (`vec[0]`→`a`, `vec[1]`→`b`, …).
- `y_in`  in  1  gate output under test.
- `busy`  out  1  high in SETTLE and SAMPLE.
- `done`  out  1  one-cycle pulse at sweep end.
- `pass`  out  1  1 when mismatch_count==0; valid from the `done` cycle; held until the next accepted start.
- `truth_table`  out  2**N_INPUTS  observed `y` per vector; bit i = sample for vec==i.
- `mismatch_count`  out  N_INPUTS+1  number of samples differing from EXPECTED.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- On `rst`, every output is 0 and the state is IDLE. This applies to `vec`, `busy`, `done`, `pass`, `truth_table` and `mismatch_count`.
- IDLE:
  - `start`=1 → SETTLE.
  - On that transition: vec←0, settle counter←0, truth_table←0, mismatch_count←0, pass←0.
- SETTLE:
  - The counter increments each cycle.
  - When counter==SETTLE_CYCLES-1 → SAMPLE, and the counter clears.
- SAMPLE:
  - truth_table[vec]←y_in.
  - If y_in≠EXPECTED[vec], mismatch_count increments.
  - If vec==2**N_INPUTS-1 → DONE; otherwise vec increments → SETTLE.
- DONE:
  - `done`=1 for exactly one cycle.
  - `pass` is registered as (final mismatch_count==0), including the last sample's compare.
  - Next state is IDLE, with vec←0.
- `start` is ignored outside IDLE, including while held high continuously.
- A new sweep begins only on a `start` seen in IDLE.
- `y_in` is not sampled in SETTLE; glitches there have no effect.
- `rst` mid-sweep aborts on the next edge, with all outputs at reset values; no `done` pulse is produced.
- mismatch_count cannot overflow: its maximum is 2**N_INPUTS and it is N_INPUTS+1 bits wide.

## Timing
- `start` is high in cycle 0 and accepted at the edge ending it.
- Vector i is driven from cycle i·(SETTLE_CYCLES+1)+1.
- Vector i is sampled in cycle (i+1)·(SETTLE_CYCLES+1).
- `done` is high in cycle 2**N_INPUTS·(SETTLE_CYCLES+1)+1. For the defaults this is cycle 13.
- `busy` is high from cycle 1 through the last SAMPLE cycle and low in DONE.
- Back-to-back sweeps: the earliest re-accept is a `start` in the cycle after DONE.
- Each `truth_table` bit updates at the edge ending its SAMPLE cycle and holds until the next accepted start.

## Configuration
- `SWEEP_EARLY_ABORT_EN` defined:
  - The first mismatching SAMPLE goes directly to DONE.
  - Unsampled truth_table bits remain 0.
  - mismatch_count is 1 and `pass`=0.
- Undefined (default): the full sweep always completes and every mismatch is counted.

## Test plan
- Ideal AND (`y_in`=vec[1]&vec[0]), defaults, 1-cycle start pulse → `done` in cycle 13, truth_table=4'b1000, mismatch_count=0, pass=1.
- `y_in` stuck at 0 → truth_table=4'b0000, mismatch_count=1, pass=0, `done` in cycle 13.
- OR gate connected with EXPECTED=4'b1000 → truth_table=4'b1110, mismatch_count=2, pass=0.
- `start` held high for 20 cycles → exactly one `done` pulse in cycle 13; a second sweep is accepted in cycle 14 and `done` pulses in cycle 27.
- `rst` high in cycle 5 → from cycle 6 all outputs are 0 and the state is IDLE with no `done`; a later start completes normally with pass=1.
- `SWEEP_EARLY_ABORT_EN` defined, `y_in` stuck at 1 → `done` in cycle 4, truth_table=4'b0001, mismatch_count=1, pass=0.
